// File: rtl/eth_probe_tx.sv
// eth_probe_tx: emits one probe frame per accepted trigger on an AXI4-Stream
// master DATA_BYTES wide. Frame = DST MAC, SRC MAC, length, identifier,
// sequence number, then PAD_BYTE padding.
// Optional build macro ETH_PROBE_TIMESTAMP_EN adds a 64-bit timestamp input
// whose sampled value is carried in the header right after the sequence number.
module eth_probe_tx #(
  parameter int          DATA_BYTES = 1,
  parameter logic [47:0] SRC_MAC    = 48'h00_00_00_00_00_00,
  parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] IDENTIFIER = 32'h0,
  parameter logic [7:0]  PAD_BYTE   = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger,
  input  logic [15:0]             padding_size,
`ifdef ETH_PROBE_TIMESTAMP_EN
  input  logic [63:0]             timestamp,
`endif
  output logic                    busy,
  output logic                    tx_begin,
  output logic                    trigger_dropped,
  output logic [31:0]             frame_seq,
  output logic [8*DATA_BYTES-1:0] m_axis_tdata,
  output logic [DATA_BYTES-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

`ifdef ETH_PROBE_TIMESTAMP_EN
  localparam int HDR = 30;
`else
  localparam int HDR = 22;
`endif
  localparam int          HW    = HDR * 8;
  localparam logic [16:0] STEP  = 17'(DATA_BYTES);
  localparam logic [16:0] HDR17 = 17'(HDR);

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAD} state_t;

  state_t                  state_q, state_d;
  logic [16:0]             cnt_q;
  logic [16:0]             total_q;
  logic [31:0]             seq_q;
  logic [31:0]             hdr_seq_q;
  logic [8*DATA_BYTES-1:0] tdata_q;
  logic [DATA_BYTES-1:0]   tkeep_q;
  logic                    tlast_q;
  logic                    tvalid_q;
`ifdef ETH_PROBE_TIMESTAMP_EN
  logic [63:0]             ts_q;
  logic [63:0]             src_ts;
`endif

  logic                    idle, hs, load_first, advance, finish;
  logic [16:0]             src_cnt, src_total;
  logic [31:0]             src_seq;
  logic [15:0]             src_len;
  logic [HW-1:0]           hdr_vec;
  logic [8*DATA_BYTES-1:0] beat_data;
  logic [DATA_BYTES-1:0]   beat_keep;
  logic                    beat_last;

  assign idle       = (state_q == ST_IDLE);
  assign hs         = tvalid_q & m_axis_tready;
  assign load_first = idle & trigger;
  assign advance    = hs & ~tlast_q;
  assign finish     = hs & tlast_q;

  // Source of the next beat: in idle it is beat 0 built from the live inputs,
  // otherwise it is the beat after the one currently on the bus.
  always_comb begin
    if (idle) begin
      src_cnt   = '0;
      src_total = {1'b0, padding_size} + HDR17;
      src_seq   = seq_q;
    end else begin
      src_cnt   = cnt_q + STEP;
      src_total = total_q;
      src_seq   = hdr_seq_q;
    end
    // total - 14 equals padding_size + (HDR - 14), truncated to 16 bits
    src_len = 16'(src_total - 17'd14);
`ifdef ETH_PROBE_TIMESTAMP_EN
    src_ts  = idle ? timestamp : ts_q;
    hdr_vec = {DST_MAC, SRC_MAC, src_len, IDENTIFIER, src_seq, src_ts};
`else
    hdr_vec = {DST_MAC, SRC_MAC, src_len, IDENTIFIER, src_seq};
`endif
  end

  // Per-lane byte selection: header byte, padding byte, or zero past the end.
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
    logic [16:0] idx;
    logic [7:0]  rev;
    logic [7:0]  lane_byte;
    logic        lane_keep;
    always_comb begin
      idx       = src_cnt + 17'(gi);
      rev       = 8'(HDR - 1) - {3'b000, idx[4:0]};
      lane_keep = (idx < src_total);
      lane_byte = 8'h00;
      if (lane_keep) lane_byte = (idx < HDR17) ? 8'(hdr_vec >> {rev, 3'b000}) : PAD_BYTE;
    end
    assign beat_data[gi*8 +: 8] = lane_byte;
    assign beat_keep[gi]        = lane_keep;
  end

  assign beat_last = ((src_cnt + STEP) >= src_total);

  // Next-state logic: header until the beat holding the last header byte is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trigger) state_d = ST_HEADER;
      ST_HEADER: if (hs) begin
                   if (tlast_q) state_d = ST_IDLE;
                   else if ((cnt_q + STEP) >= HDR17) state_d = ST_PAD;
                 end
      ST_PAD:    if (hs && tlast_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output beat registers, byte counter and sequence bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      total_q   <= '0;
      seq_q     <= '0;
      hdr_seq_q <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
`ifdef ETH_PROBE_TIMESTAMP_EN
      ts_q      <= '0;
`endif
    end else if (load_first) begin
      cnt_q     <= '0;
      total_q   <= src_total;
      hdr_seq_q <= seq_q;
`ifdef ETH_PROBE_TIMESTAMP_EN
      ts_q      <= timestamp;
`endif
      tdata_q   <= beat_data;
      tkeep_q   <= beat_keep;
      tlast_q   <= beat_last;
      tvalid_q  <= 1'b1;
    end else if (advance) begin
      cnt_q     <= src_cnt;
      tdata_q   <= beat_data;
      tkeep_q   <= beat_keep;
      tlast_q   <= beat_last;
    end else if (finish) begin
      seq_q     <= seq_q + 32'd1;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
    end
  end

  assign busy            = ~rst & ~idle;
  assign tx_begin        = ~rst & hs & (cnt_q == 17'd0);
  assign trigger_dropped = ~rst & trigger & ~idle;
  assign frame_seq       = seq_q;
  assign m_axis_tdata    = tdata_q;
  assign m_axis_tkeep    = tkeep_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tvalid   = tvalid_q;

endmodule

// File: tb/tb_eth_probe_tx.sv
// Bench for eth_probe_tx: four instances (1, 2, 4, 8 byte lanes) observed
// through a shared selector; directed frames checked against a byte model.
module tb_eth_probe_tx;

  localparam logic [47:0] SRC_M = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [47:0] DST_M = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] IDENT = 32'hCAFE_BABE;
  localparam logic [7:0]  PAD   = 8'h20;
`ifdef ETH_PROBE_TIMESTAMP_EN
  localparam int HDR_E = 30;
`else
  localparam int HDR_E = 22;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  trig, tready;
  logic [15:0] pad_w [4];
  logic [63:0] tsv;
  logic [3:0]  busy_w, txb_w, drop_w, last_w, valid_w;
  logic [31:0] seq_w [4];
  logic [7:0]  keep_w [4];
  logic [63:0] data_w [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int DB = 1 << gi;
    logic [8*DB-1:0] d;
    logic [DB-1:0]   k;
    eth_probe_tx #(.DATA_BYTES(DB), .SRC_MAC(SRC_M), .DST_MAC(DST_M),
                   .IDENTIFIER(IDENT), .PAD_BYTE(PAD)) u (
      .clk(clk), .rst(rst), .trigger(trig[gi]), .padding_size(pad_w[gi]),
`ifdef ETH_PROBE_TIMESTAMP_EN
      .timestamp(tsv),
`endif
      .busy(busy_w[gi]), .tx_begin(txb_w[gi]), .trigger_dropped(drop_w[gi]),
      .frame_seq(seq_w[gi]), .m_axis_tdata(d), .m_axis_tkeep(k),
      .m_axis_tlast(last_w[gi]), .m_axis_tvalid(valid_w[gi]),
      .m_axis_tready(tready[gi])
    );
    assign data_w[gi] = 64'(d);
    assign keep_w[gi] = 8'(k);
  end

  logic [1:0]  sel;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic        o_last, o_valid, o_busy, o_txb, o_drop;
  logic [31:0] o_seq;

  always_comb begin
    o_data  = data_w[sel];
    o_keep  = keep_w[sel];
    o_last  = last_w[sel];
    o_valid = valid_w[sel];
    o_busy  = busy_w[sel];
    o_txb   = txb_w[sel];
    o_drop  = drop_w[sel];
    o_seq   = seq_w[sel];
  end

  int total = 0;
  int bad   = 0;

  // capture results of the last frame
  logic [7:0]  rx [0:255];
  logic [7:0]  bkeep [0:63];
  logic [63:0] bdata [0:63];
  int rx_n, beats, last_cnt, last_beat, txb_cnt, txb_beat, first_lat;
  int lane_bad, stab_bad, drop_bad, drop_cnt, vdrop;
  bit timed_out;

  function automatic logic [7:0] exp_byte(input int i, input int p, input logic [31:0] s);
    logic [47:0] dm, sm;
    logic [31:0] idv;
    logic [15:0] len;
    logic [63:0] tv;
    dm = DST_M; sm = SRC_M; idv = IDENT; tv = tsv;
    len = 16'(p + HDR_E - 14);
    if (i < 6)     return dm[8*(5-i) +: 8];
    if (i < 12)    return sm[8*(11-i) +: 8];
    if (i == 12)   return len[15:8];
    if (i == 13)   return len[7:0];
    if (i < 18)    return idv[8*(17-i) +: 8];
    if (i < 22)    return s[8*(21-i) +: 8];
    if (i < HDR_E) return tv[8*(29-i) +: 8];
    return PAD;
  endfunction

  // Triggers instance s at the current negedge and records the frame.
  task automatic run_frame(input int s, input logic [15:0] p, input bit toggle, input bit hold);
    bit done, prev_stall, seen;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    int cyc;
    sel = 2'(s); pad_w[s] = p; trig[s] = 1'b1; tready[s] = 1'b1;
    rx_n = 0; beats = 0; last_cnt = 0; last_beat = -1; txb_cnt = 0; txb_beat = -1;
    first_lat = -1; lane_bad = 0; stab_bad = 0; drop_bad = 0; drop_cnt = 0; vdrop = 0;
    hd = '0; hk = '0; hl = 1'b0;
    @(negedge clk);
    if (!hold) trig[s] = 1'b0;
    done = 0; prev_stall = 0; seen = 0; cyc = 0;
    while (!done && cyc < 300) begin
      if (toggle) tready[s] = ~tready[s];
      #1;
      if (o_valid) begin
        if (!seen) begin first_lat = cyc; seen = 1; end
        if (prev_stall && (o_data !== hd || o_keep !== hk || o_last !== hl)) stab_bad++;
        if (o_txb) begin txb_cnt++; txb_beat = beats + 1; end
        if (tready[s]) begin
          bkeep[beats] = o_keep; bdata[beats] = o_data; beats++;
          for (int l = 0; l < 8; l++) begin
            if (o_keep[l]) begin rx[rx_n] = o_data[8*l +: 8]; rx_n++; end
            else if (o_data[8*l +: 8] !== 8'h00) lane_bad++;
          end
          if (o_last) begin last_cnt++; last_beat = beats; done = 1; end
          prev_stall = 0;
        end else begin
          prev_stall = 1; hd = o_data; hk = o_keep; hl = o_last;
        end
      end else if (seen) vdrop++;
      if (hold) begin
        if (o_drop !== (o_busy & trig[s])) drop_bad++;
        if (o_drop) drop_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      total++; if (o_valid !== 1'b0 || o_last !== 1'b0) begin bad++; $display("FAIL reset_vl[%0d] got valid=%b last=%b exp 0 0", s, o_valid, o_last); end
      total++; if (o_keep !== 8'h00 || o_data !== 64'h0) begin bad++; $display("FAIL reset_dk[%0d] got keep=%h data=%h exp 0", s, o_keep, o_data); end
      total++; if (o_busy !== 1'b0 || o_txb !== 1'b0 || o_drop !== 1'b0) begin bad++; $display("FAIL reset_flags[%0d] got busy=%b txb=%b drop=%b exp 0", s, o_busy, o_txb, o_drop); end
      total++; if (o_seq !== 32'h0) begin bad++; $display("FAIL reset_seq[%0d] got=%h exp=0", s, o_seq); end
    end
    @(negedge clk);
    $display("test_reset: checked 4 instances");
  endtask

  task automatic test_db1();
    int mm;
    run_frame(0, 16'd0, 0, 0);
    mm = 0; for (int i = 0; i < rx_n; i++) if (rx[i] !== exp_byte(i, 0, 32'h0)) mm++;
    total++; if (timed_out) begin bad++; $display("FAIL db1_timeout got=timeout exp=tlast"); end
    total++; if (beats !== HDR_E) begin bad++; $display("FAIL db1_beats got=%0d exp=%0d", beats, HDR_E); end
    total++; if (first_lat !== 0) begin bad++; $display("FAIL db1_latency got=%0d exp=0", first_lat); end
    total++; if (txb_cnt !== 1 || txb_beat !== 1) begin bad++; $display("FAIL db1_txbegin got cnt=%0d beat=%0d exp 1 1", txb_cnt, txb_beat); end
    total++; if (last_cnt !== 1 || last_beat !== HDR_E) begin bad++; $display("FAIL db1_tlast got cnt=%0d beat=%0d exp 1 %0d", last_cnt, last_beat, HDR_E); end
    total++; if ({rx[12], rx[13]} !== 16'(HDR_E - 14)) begin bad++; $display("FAIL db1_len got=%h%h exp=%h", rx[12], rx[13], 16'(HDR_E - 14)); end
    total++; if ({rx[18], rx[19], rx[20], rx[21]} !== 32'h0) begin bad++; $display("FAIL db1_seqfield got=%h%h%h%h exp=00000000", rx[18], rx[19], rx[20], rx[21]); end
    total++; if (mm !== 0 || rx_n !== HDR_E) begin bad++; $display("FAIL db1_bytes got mism=%0d n=%0d exp 0 %0d", mm, rx_n, HDR_E); end
    #1;
    total++; if (o_seq !== 32'd1) begin bad++; $display("FAIL db1_frame_seq got=%h exp=1", o_seq); end
    total++; if (vdrop !== 0 || lane_bad !== 0) begin bad++; $display("FAIL db1_axis got vdrop=%0d lanebad=%0d exp 0 0", vdrop, lane_bad); end
    $display("test_db1: beats=%0d bytes=%0d", beats, rx_n);
  endtask

  task automatic test_db4();
    int nb, kb, mm;
    run_frame(2, 16'd3, 0, 0);
    nb = (HDR_E + 3 + 3) / 4;
    kb = 0; for (int b = 0; b < nb - 1; b++) if (bkeep[b] !== 8'h0F) kb++;
    mm = 0; for (int i = 0; i < rx_n; i++) if (rx[i] !== exp_byte(i, 3, 32'h0)) mm++;
    total++; if (timed_out || beats !== nb) begin bad++; $display("FAIL db4_beats got=%0d to=%0d exp=%0d", beats, timed_out, nb); end
    total++; if (last_cnt !== 1 || last_beat !== nb) begin bad++; $display("FAIL db4_tlast got cnt=%0d beat=%0d exp 1 %0d", last_cnt, last_beat, nb); end
`ifndef ETH_PROBE_TIMESTAMP_EN
    total++; if (bdata[5] !== 64'h2020_0000) begin bad++; $display("FAIL db4_beat6 got=%h exp=20200000", bdata[5]); end
    total++; if (bkeep[6] !== 8'h01 || bdata[6] !== 64'h20) begin bad++; $display("FAIL db4_lastbeat got keep=%h data=%h exp 01 00000020", bkeep[6], bdata[6]); end
`endif
    total++; if (kb !== 0) begin bad++; $display("FAIL db4_keep_full got bad=%0d exp=0", kb); end
    total++; if (mm !== 0 || lane_bad !== 0) begin bad++; $display("FAIL db4_bytes got mism=%0d lanebad=%0d exp 0 0", mm, lane_bad); end
    $display("test_db4: beats=%0d bytes=%0d", beats, rx_n);
  endtask

  task automatic test_db8_stall();
    int mm;
    run_frame(3, 16'd10, 1, 0);
    mm = 0; for (int i = 0; i < rx_n; i++) if (rx[i] !== exp_byte(i, 10, 32'h0)) mm++;
    total++; if (timed_out || beats !== (HDR_E + 10 + 7) / 8) begin bad++; $display("FAIL db8_beats got=%0d to=%0d exp=%0d", beats, timed_out, (HDR_E + 17) / 8); end
    total++; if (stab_bad !== 0) begin bad++; $display("FAIL db8_stable got changes=%0d exp=0", stab_bad); end
    total++; if ({rx[12], rx[13]} !== 16'(HDR_E - 4)) begin bad++; $display("FAIL db8_len got=%h%h exp=%h", rx[12], rx[13], 16'(HDR_E - 4)); end
    total++; if (txb_cnt !== 1 || txb_beat !== 1) begin bad++; $display("FAIL db8_txbegin got cnt=%0d beat=%0d exp 1 1", txb_cnt, txb_beat); end
`ifndef ETH_PROBE_TIMESTAMP_EN
    total++; if (bkeep[3] !== 8'hFF) begin bad++; $display("FAIL db8_lastkeep got=%h exp=ff", bkeep[3]); end
`endif
    total++; if (mm !== 0 || vdrop !== 0) begin bad++; $display("FAIL db8_bytes got mism=%0d vdrop=%0d exp 0 0", mm, vdrop); end
    $display("test_db8_stall: beats=%0d bytes=%0d", beats, rx_n);
  endtask

  task automatic test_back_to_back();
    run_frame(1, 16'd0, 0, 1);
    total++; if (timed_out || beats !== HDR_E / 2) begin bad++; $display("FAIL b2b_beats1 got=%0d exp=%0d", beats, HDR_E / 2); end
    total++; if (drop_bad !== 0 || drop_cnt !== HDR_E / 2) begin bad++; $display("FAIL b2b_drop1 got bad=%0d cnt=%0d exp 0 %0d", drop_bad, drop_cnt, HDR_E / 2); end
    #1;
    total++; if (o_busy !== 1'b0 || o_drop !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b drop=%b exp 0 0", o_busy, o_drop); end
    run_frame(1, 16'd0, 0, 1);
    trig[1] = 1'b0;
    total++; if (timed_out || first_lat !== 0 || beats !== HDR_E / 2) begin bad++; $display("FAIL b2b_frame2 got lat=%0d beats=%0d exp 0 %0d", first_lat, beats, HDR_E / 2); end
    total++; if ({rx[18], rx[19], rx[20], rx[21]} !== 32'd1) begin bad++; $display("FAIL b2b_seq got=%h%h%h%h exp=00000001", rx[18], rx[19], rx[20], rx[21]); end
    total++; if (drop_bad !== 0 || drop_cnt !== HDR_E / 2) begin bad++; $display("FAIL b2b_drop2 got bad=%0d cnt=%0d exp 0 %0d", drop_bad, drop_cnt, HDR_E / 2); end
    #1;
    total++; if (o_seq !== 32'd2) begin bad++; $display("FAIL b2b_frame_seq got=%h exp=2", o_seq); end
    $display("test_back_to_back: two frames, drops=%0d", drop_cnt);
  endtask

  task automatic test_wrap();
    int mm;
    sel = 2'd3;
    force g_dut[3].u.seq_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release g_dut[3].u.seq_q;
    #1;
    total++; if (o_seq !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_forced got=%h exp=ffffffff", o_seq); end
    run_frame(3, 16'd0, 0, 0);
    mm = 0; for (int i = 0; i < rx_n; i++) if (rx[i] !== exp_byte(i, 0, 32'hFFFF_FFFF)) mm++;
    total++; if ({rx[18], rx[19], rx[20], rx[21]} !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_seqfield got=%h%h%h%h exp=ffffffff", rx[18], rx[19], rx[20], rx[21]); end
`ifndef ETH_PROBE_TIMESTAMP_EN
    total++; if (beats !== 3 || bkeep[2] !== 8'h3F) begin bad++; $display("FAIL wrap_last got beats=%0d keep=%h exp 3 3f", beats, bkeep[2]); end
`endif
    total++; if (mm !== 0 || timed_out) begin bad++; $display("FAIL wrap_bytes got mism=%0d to=%0d exp 0 0", mm, timed_out); end
    #1;
    total++; if (o_seq !== 32'h0) begin bad++; $display("FAIL wrap_after got=%h exp=0", o_seq); end
    $display("test_wrap: seq wrapped to %h", o_seq);
  endtask

  task automatic test_reset_mid();
    int mm;
    sel = 2'd0; pad_w[0] = 16'd0; tready[0] = 1'b1; trig[0] = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (o_valid !== 1'b1 || o_last !== 1'b0 || o_data !== 64'hFF) begin bad++; $display("FAIL rmid_beat5 got valid=%b last=%b data=%h exp 1 0 ff", o_valid, o_last, o_data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_last !== 1'b0) begin bad++; $display("FAIL rmid_abort got valid=%b busy=%b last=%b exp 0 0 0", o_valid, o_busy, o_last); end
    total++; if (o_seq !== 32'h0) begin bad++; $display("FAIL rmid_seq got=%h exp=0", o_seq); end
    run_frame(0, 16'd0, 0, 0);
    mm = 0; for (int i = 0; i < rx_n; i++) if (rx[i] !== exp_byte(i, 0, 32'h0)) mm++;
    total++; if (timed_out || beats !== HDR_E || mm !== 0) begin bad++; $display("FAIL rmid_frame got beats=%0d mism=%0d exp %0d 0", beats, mm, HDR_E); end
    $display("test_reset_mid: refill beats=%0d", beats);
  endtask

`ifdef ETH_PROBE_TIMESTAMP_EN
  task automatic test_timestamp();
    int mm;
    tsv = 64'h0102_0304_0506_0708;
    run_frame(3, 16'd2, 0, 0);
    mm = 0; for (int i = 0; i < rx_n; i++) if (rx[i] !== exp_byte(i, 2, 32'h0)) mm++;
    total++; if ({rx[22], rx[23], rx[24], rx[25], rx[26], rx[27], rx[28], rx[29]} !== 64'h0102_0304_0506_0708) begin bad++; $display("FAIL ts_field got=%h%h%h%h%h%h%h%h exp=0102030405060708", rx[22], rx[23], rx[24], rx[25], rx[26], rx[27], rx[28], rx[29]); end
    total++; if ({rx[12], rx[13]} !== 16'h0012) begin bad++; $display("FAIL ts_len got=%h%h exp=0012", rx[12], rx[13]); end
    total++; if (rx_n !== 32 || beats !== 4 || mm !== 0) begin bad++; $display("FAIL ts_frame got n=%0d beats=%0d mism=%0d exp 32 4 0", rx_n, beats, mm); end
    $display("test_timestamp: bytes=%0d", rx_n);
  endtask
`endif

  initial begin
    rst = 1'b1; trig = '0; tready = '0; sel = '0; tsv = 64'h0;
    for (int s = 0; s < 4; s++) pad_w[s] = 16'd0;
    test_reset();
    test_db1();
    test_db4();
    test_db8_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef ETH_PROBE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
